// File: rtl/ymux_rr_arb_pkg.sv
// Shared definitions for the ymux arbiters: arbitration mode encodings and
// the channel-index width helper.
package ymux_rr_arb_pkg;

    typedef enum logic {
        MODE_RR    = 1'b0,
        MODE_FIXED = 1'b1
    } arb_mode_e;

    // Index width for n channels; never narrower than one bit.
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ymux_rr_arb_pick.sv
// Rotating-priority picker: first asserted req searching ptr, ptr+1, ... mod N.
// Emits a one-hot grant and its encoded index; both zero when req is zero.
module rr_pick
    import ymux_rr_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = chan_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/ymux_rr_arb.sv
// N-to-1 arbitrated mux with a single registered output stage that sustains
// one beat per cycle; round-robin or fixed priority selected by MODE.
module ymux_rr_arb
    import ymux_rr_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int MODE  = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N-1:0]           in_valid,
    input  logic [N*WIDTH-1:0]     in_data,
    output logic [N-1:0]           in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [chan_w(N)-1:0]   out_chan
);

    localparam int  CW    = chan_w(N);
    localparam bit  FIXED = (MODE == int'(MODE_FIXED));

    logic [CW-1:0]    ptr_q, ptr_d, pick_ptr, gnt_idx;
    logic [N-1:0]     gnt;
    logic             load_en, in_xfer;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CW-1:0]    out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;

    assign pick_ptr = FIXED ? '0 : ptr_q;

    rr_pick #(.N(N), .IW(CW)) u_pick (
        .req (in_valid),
        .ptr (pick_ptr),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    // rst_n gates in_ready so no handshake can be seen while in reset.
    assign load_en  = ~out_valid_q | out_ready;
    assign in_ready = gnt & {N{load_en & rst_n}};
    assign in_xfer  = |in_ready;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{gnt[i]}});
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        if (in_xfer) begin
            out_data_d  = sel_data;
            out_chan_d  = gnt_idx;
            out_valid_d = 1'b1;
            if (!FIXED) begin
                ptr_d = (gnt_idx == CW'(N - 1)) ? '0 : gnt_idx + CW'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_ymux_rr_arb.sv
// Scoreboard bench: three arbiter instances (RR N=4, fixed N=4, RR N=3 W=8)
// share stimulus; a queue model predicts grants and a monitor checks delivery.
module tb_ymux_rr_arb;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      in_v;
    logic [3:0][31:0] in_d;
    logic            out_ready;

    logic [3:0]  ir0, ir1;
    logic [2:0]  ir2;
    logic        ov0, ov1, ov2;
    logic [31:0] od0, od1;
    logic [7:0]  od2;
    logic [1:0]  oc0, oc1, oc2;

    always #5 clk = ~clk;

    ymux_rr_arb #(.WIDTH(32), .N(4), .MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_v), .in_data(in_d), .in_ready(ir0),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_chan(oc0));

    ymux_rr_arb #(.WIDTH(32), .N(4), .MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_v), .in_data(in_d), .in_ready(ir1),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_chan(oc1));

    ymux_rr_arb #(.WIDTH(8), .N(3), .MODE(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_v[2:0]),
        .in_data({in_d[2][7:0], in_d[1][7:0], in_d[0][7:0]}), .in_ready(ir2),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_chan(oc2));

    int          act;
    logic        a_ov;
    logic [31:0] a_od;
    logic [1:0]  a_oc;
    logic [3:0]  a_ir;

    always_comb begin
        a_ov = ov0; a_od = od0; a_oc = oc0; a_ir = ir0;
        if (act == 1) begin
            a_ov = ov1; a_od = od1; a_oc = oc1; a_ir = ir1;
        end else if (act == 2) begin
            a_ov = ov2; a_od = {24'h0, od2}; a_oc = oc2; a_ir = {1'b0, ir2};
        end
    end

    typedef struct {
        int          chan;
        logic [31:0] data;
    } beat_t;

    beat_t exp_q[$];
    beat_t mb;
    int    seen[$];
    int    total = 0, bad = 0;
    int    mptr, pushed, popped;
    bit    mvalid;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic int m_n();
        return (act == 2) ? 3 : 4;
    endfunction

    function automatic bit m_fixed();
        return act == 1;
    endfunction

    // First valid channel scanning from p upward, wrapping modulo n; -1 if none.
    function automatic int pick(input logic [3:0] v, input int p, input int n);
        for (int k = 0; k < n; k++)
            if (v[(p + k) % n]) return (p + k) % n;
        return -1;
    endfunction

    // Inputs are set by the caller just after a rising edge; the model advances
    // on the following falling edge and the call returns just after the next rise.
    task automatic cycle();
        int          g;
        bit          le;
        logic [3:0]  er;
        logic [31:0] mask;
        mask = (act == 2) ? 32'hFF : 32'hFFFF_FFFF;
        @(negedge clk);
        le = !mvalid || out_ready;
        g  = pick(in_v, m_fixed() ? 0 : mptr, m_n());
        er = (le && g >= 0) ? 4'(1 << g) : 4'b0;
        chk("in_ready", 64'(a_ir), 64'(er));
        chk("out_valid", 64'(a_ov), 64'(mvalid));
        if (er != 4'b0) begin
            exp_q.push_back('{g, in_d[g] & mask});
            pushed++;
            mvalid = 1'b1;
            if (!m_fixed()) mptr = (g + 1) % m_n();
        end else if (out_ready) begin
            mvalid = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int a);
        act = a; rst_n = 1'b0; in_v = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        exp_q.delete(); seen.delete();
        mptr = 0; mvalid = 1'b0; pushed = 0; popped = 0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < 4; i++) in_d[i] = $urandom();
    endtask

    // Monitor: an output transfer happens at the coming edge; check it against the queue head.
    always @(negedge clk) begin
        if (rst_n && a_ov && out_ready) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_beat: got chan %0d data %0h expected none", a_oc, a_od);
            end else begin
                mb = exp_q.pop_front();
                chk("out_chan", 64'(a_oc), 64'(mb.chan));
                chk("out_data", 64'(a_od), 64'(mb.data));
                popped++;
            end
            seen.push_back(int'(a_oc));
        end
    end

    initial begin
        rst_n = 1'b0; act = 0; in_v = 4'hF; out_ready = 1'b1; rand_data();
        #2;
        chk("rst_out_valid", 64'(a_ov), 0);
        chk("rst_out_data", 64'(a_od), 0);
        chk("rst_out_chan", 64'(a_oc), 0);
        chk("rst_in_ready", 64'(a_ir), 0);

        // Round-robin fairness with all channels requesting.
        do_reset(0);
        in_v = 4'hF; out_ready = 1'b1;
        repeat (9) begin rand_data(); cycle(); end
        chk("rr_count", 64'(seen.size()), 8);
        for (int i = 0; i < 8 && i < seen.size(); i++)
            chk("rr_seq", 64'(seen[i]), 64'(i % 4));

        // Skip and wrap: ptr to 3 via channel 2, then 0101 grants 0 then 2.
        do_reset(0);
        out_ready = 1'b1;
        in_v = 4'b0100; rand_data(); cycle();
        in_v = 4'b0101; rand_data(); cycle();
        rand_data(); cycle();
        in_v = 4'b0000; cycle();
        chk("wrap_count", 64'(seen.size()), 3);
        if (seen.size() == 3) begin
            chk("wrap_0", 64'(seen[0]), 2);
            chk("wrap_1", 64'(seen[1]), 0);
            chk("wrap_2", 64'(seen[2]), 2);
        end

        // Backpressure holds the beat; release loads channel 1 on the same edge.
        do_reset(0);
        in_v = 4'b0001; in_d[0] = 32'hDEAD_BEEF; out_ready = 1'b0; cycle();
        in_v = 4'b0010; in_d[1] = 32'h1234_5678;
        repeat (5) begin
            cycle();
            chk("bp_data", 64'(a_od), 64'h0000_0000_DEAD_BEEF);
            chk("bp_ready", 64'(a_ir), 0);
        end
        out_ready = 1'b1; cycle();
        chk("bp_new_data", 64'(a_od), 64'h0000_0000_1234_5678);
        chk("bp_new_chan", 64'(a_oc), 1);
        in_v = 4'b0000; cycle();

        // Reset asserted with a beat held clears outputs without a clock edge.
        in_v = 4'b0100; out_ready = 1'b0; cycle();
        chk("mid_loaded", 64'(a_ov), 1);
        rst_n = 1'b0; #1;
        chk("mid_rst_valid", 64'(a_ov), 0);
        chk("mid_rst_chan", 64'(a_oc), 0);
        chk("mid_rst_ready", 64'(a_ir), 0);

        // After reset the first grant starts from channel 0.
        do_reset(0);
        in_v = 4'b1001; out_ready = 1'b1; cycle();
        chk("post_rst_chan", 64'(a_oc), 0);
        in_v = 4'b0000; cycle();

        // Fixed priority starves channels 2 and 3.
        do_reset(1);
        in_v = 4'b1110; out_ready = 1'b1;
        repeat (6) begin rand_data(); cycle(); end
        chk("fixed_count", 64'(seen.size()), 5);
        foreach (seen[i]) chk("fixed_chan", 64'(seen[i]), 1);

        // Random traffic on the 3-channel, 8-bit instance.
        do_reset(2);
        repeat (10000) begin
            in_v = 4'($urandom_range(0, 7));
            rand_data();
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        in_v = 4'b0000; out_ready = 1'b1;
        repeat (3) cycle();
        chk("drain_empty", 64'(exp_q.size()), 0);
        chk("delivered_all", 64'(popped), 64'(pushed));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
